// File: rtl/sobel_sched_pkg.sv
// sobel_sched_pkg: shared state encoding and constants for sobel_frame_scheduler
package sobel_sched_pkg;
    localparam int DEFAULT_DIM_W = 16;
    localparam int MIN_DIM = 3;
    typedef enum logic [2:0] {IDLE, CHECK, READ, SOBEL, WRITE, ADVANCE, DONE, ERROR} sched_state_t;
endpackage

// File: rtl/sobel_frame_scheduler_if.sv
// sobel_frame_scheduler_if: handshake between the scheduler, ahb_master and the Sobel core
interface sobel_frame_scheduler_if;
    logic read_enable;
    logic write_enable;
    logic sobel_start;
    logic transfer_data_complete_r;
    logic transfer_data_complete_w;
    logic sobel_done;
    modport master (
        output read_enable, write_enable, sobel_start,
        input  transfer_data_complete_r, transfer_data_complete_w, sobel_done
    );
    modport slave (
        input  read_enable, write_enable, sobel_start,
        output transfer_data_complete_r, transfer_data_complete_w, sobel_done
    );
endinterface

// File: rtl/sobel_pos_counter.sv
// sobel_pos_counter: output window column/row stepping with single_last and last-step detection
module sobel_pos_counter
    import sobel_sched_pkg::*;
#(
    parameter int DIM_W = DEFAULT_DIM_W
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [DIM_W:0]   i_out_cols,
    input  logic [DIM_W:0]   i_out_rows,
    output logic [DIM_W-1:0] o_col_idx,
    output logic [DIM_W-1:0] o_row_idx,
    output logic             o_single_last,
    output logic             o_last_step
);
    logic [DIM_W:0]   w_col_step, w_row_step;
    logic             w_col_more, w_row_more;
    logic [DIM_W-1:0] w_col_nxt, w_row_nxt;
    assign w_col_step  = {1'b0, o_col_idx} + (DIM_W+1)'(2);
    assign w_row_step  = {1'b0, o_row_idx} + (DIM_W+1)'(1);
    assign w_col_more  = w_col_step < i_out_cols;
    assign w_row_more  = w_row_step < i_out_rows;
    assign o_last_step = !w_col_more && !w_row_more;
    assign w_col_nxt = i_clear                   ? '0 :
                       i_advance && w_col_more   ? w_col_step[DIM_W-1:0] :
                       i_advance && w_row_more   ? '0 : o_col_idx;
    assign w_row_nxt = i_clear                                ? '0 :
                       i_advance && !w_col_more && w_row_more ? w_row_step[DIM_W-1:0] : o_row_idx;
    // single_last tracks the column the step will actually use, so it lines up with col_idx
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            o_col_idx     <= '0;
            o_row_idx     <= '0;
            o_single_last <= 1'b0;
        end else begin
            o_col_idx     <= w_col_nxt;
            o_row_idx     <= w_row_nxt;
            o_single_last <= ({1'b0, w_col_nxt} + (DIM_W+1)'(1)) == i_out_cols;
        end
    end
endmodule

// File: rtl/sobel_frame_scheduler.sv
// sobel_frame_scheduler: frame sequencer driving read/Sobel/write steps per 3x3 window.
// Optional watchdog on wait states when SCHED_TIMEOUT_EN is defined.
module sobel_frame_scheduler
    import sobel_sched_pkg::*;
#(
    parameter int DIM_W          = DEFAULT_DIM_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DIM_W-1:0]        img_length,
    input  logic [DIM_W-1:0]        img_width,
    sobel_frame_scheduler_if.master bus,
    output logic [DIM_W-1:0]        col_idx,
    output logic [DIM_W-1:0]        row_idx,
    output logic                    single_last,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    error
);
    sched_state_t     r_state, w_next;
    logic [DIM_W-1:0] r_len, r_wid;
    logic [DIM_W:0]   w_out_cols, w_out_rows;
    logic             w_accept, w_last, w_timeout, w_bad_dim;
    assign w_accept   = (r_state == IDLE) && start && !abort;
    assign w_out_cols = {1'b0, r_len} - (DIM_W+1)'(2);
    assign w_out_rows = {1'b0, r_wid} - (DIM_W+1)'(2);
    assign w_bad_dim  = (r_len < DIM_W'(MIN_DIM)) || (r_wid < DIM_W'(MIN_DIM));
`ifdef SCHED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WAIT_W-1:0] r_wait;
    assign w_timeout = (r_state inside {READ, SOBEL, WRITE}) && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_wait <= '0;
        else          r_wait <= (w_next == r_state) ? r_wait + WAIT_W'(1) : '0;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? CHECK : IDLE;
            CHECK:   w_next = w_bad_dim ? ERROR : READ;
            READ:    w_next = bus.transfer_data_complete_r ? SOBEL : w_timeout ? ERROR : READ;
            SOBEL:   w_next = bus.sobel_done ? WRITE : w_timeout ? ERROR : SOBEL;
            WRITE:   w_next = bus.transfer_data_complete_w ? ADVANCE : w_timeout ? ERROR : WRITE;
            ADVANCE: w_next = w_last ? DONE : READ;
            default: w_next = IDLE;
        endcase
        if (abort) w_next = IDLE;
    end
    // every output is a register loaded from the next state
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state          <= IDLE;
            r_len            <= '0;
            r_wid            <= '0;
            bus.read_enable  <= 1'b0;
            bus.write_enable <= 1'b0;
            bus.sobel_start  <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            error            <= 1'b0;
        end else begin
            r_state          <= w_next;
            r_len            <= w_accept ? img_length : r_len;
            r_wid            <= w_accept ? img_width : r_wid;
            bus.read_enable  <= w_next == READ;
            bus.write_enable <= w_next == WRITE;
            bus.sobel_start  <= (w_next == SOBEL) && (r_state != SOBEL);
            busy             <= w_next inside {CHECK, READ, SOBEL, WRITE, ADVANCE};
            frame_done       <= w_next == DONE;
            error            <= w_accept ? 1'b0 : (w_next == ERROR) ? 1'b1 : error;
        end
    end
    sobel_pos_counter #(.DIM_W(DIM_W)) u_pos (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .i_clear       (w_accept),
        .i_advance     ((r_state == ADVANCE) && !abort),
        .i_out_cols    (w_out_cols),
        .i_out_rows    (w_out_rows),
        .o_col_idx     (col_idx),
        .o_row_idx     (row_idx),
        .o_single_last (single_last),
        .o_last_step   (w_last)
    );
endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// tb_sobel_frame_scheduler: table, hand-written and random frame checks against a window-walk model
module tb_sobel_frame_scheduler;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] img_length = '0;
    logic [15:0] img_width = '0;
    logic [15:0] col_idx, row_idx;
    logic        single_last, busy, frame_done, error;
    int          checks = 0;
    int          errors = 0;
    int          m_col[$];
    int          m_row[$];
    int          m_sl[$];

    sobel_frame_scheduler_if bus();

    sobel_frame_scheduler #(.DIM_W(16), .TIMEOUT_CYCLES(16)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .start       (start),
        .abort       (abort),
        .img_length  (img_length),
        .img_width   (img_width),
        .bus         (bus.master),
        .col_idx     (col_idx),
        .row_idx     (row_idx),
        .single_last (single_last),
        .busy        (busy),
        .frame_done  (frame_done),
        .error       (error)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int len;
        int wid;
        int exp_err;
        int exp_steps;
    } vec_t;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // window positions in visiting order, straight from the frame geometry
    task automatic build_model(input int len, input int wid);
        m_col.delete();
        m_row.delete();
        m_sl.delete();
        for (int r = 0; r < wid - 2; r++)
            for (int c = 0; c < len - 2; c += 2) begin
                m_col.push_back(c);
                m_row.push_back(r);
                m_sl.push_back((c + 1 == len - 2) ? 1 : 0);
            end
    endtask

    task automatic run_frame(input int len, input int wid, input int max_lat, output int steps);
        bit done = 0;
        int lat;
        build_model(len, wid);
        img_length = 16'(len);
        img_width = 16'(wid);
        start = 1;
        tick();
        start = 0;
        chk("check_busy", busy, 1);
        chk("start_clears_error", error, 0);
        chk("start_col0", col_idx, 0);
        chk("start_row0", row_idx, 0);
        tick();
        steps = 0;
        while (!done && steps < 64) begin
            chk("rd_en_on", bus.read_enable, 1);
            chk("wr_en_off_in_read", bus.write_enable, 0);
            if (steps < m_col.size()) begin
                chk("col_idx", col_idx, m_col[steps]);
                chk("row_idx", row_idx, m_row[steps]);
                chk("single_last", single_last, m_sl[steps]);
            end
            lat = $urandom_range(0, max_lat);
            for (int i = 0; i < lat; i++) begin
                bus.sobel_done = 1'($urandom_range(0, 1));
                tick();
                chk("rd_en_hold", bus.read_enable, 1);
                chk("stray_done_no_start", bus.sobel_start, 0);
            end
            bus.sobel_done = 0;
            bus.transfer_data_complete_r = 1;
            tick();
            bus.transfer_data_complete_r = 0;
            chk("rd_en_drop", bus.read_enable, 0);
            chk("sobel_start_pulse", bus.sobel_start, 1);
            lat = $urandom_range(0, max_lat);
            for (int i = 0; i < lat; i++) begin
                tick();
                chk("sobel_start_once", bus.sobel_start, 0);
                chk("wr_en_wait_sobel", bus.write_enable, 0);
            end
            bus.sobel_done = 1;
            tick();
            bus.sobel_done = 0;
            chk("wr_en_on", bus.write_enable, 1);
            lat = $urandom_range(0, max_lat);
            for (int i = 0; i < lat; i++) tick();
            bus.transfer_data_complete_w = 1;
            tick();
            bus.transfer_data_complete_w = 0;
            chk("advance_wr_off", bus.write_enable, 0);
            chk("advance_rd_off", bus.read_enable, 0);
            chk("advance_busy", busy, 1);
            chk("advance_no_done", frame_done, 0);
            tick();
            steps++;
            done = frame_done;
        end
        chk("frame_done_seen", done, 1);
        chk("done_busy_low", busy, 0);
        chk("done_rd_off", bus.read_enable, 0);
        tick();
        chk("frame_done_single_pulse", frame_done, 0);
        chk("idle_busy_low", busy, 0);
    endtask

    task automatic run_err(input int len, input int wid);
        img_length = 16'(len);
        img_width = 16'(wid);
        start = 1;
        tick();
        start = 0;
        tick();
        chk("err_raised", error, 1);
        chk("err_busy_low", busy, 0);
        chk("err_no_read", bus.read_enable, 0);
        tick();
        chk("err_sticky", error, 1);
        chk("err_idle_no_read", bus.read_enable, 0);
        chk("err_idle_busy", busy, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int   steps;
        int   n;
        vecs[0] = '{12, 5, 0, 15};
        vecs[1] = '{5, 3, 0, 2};
        vecs[2] = '{2, 5, 1, 0};
        vecs[3] = '{3, 3, 0, 1};
        vecs[4] = '{4, 4, 0, 2};
        vecs[5] = '{7, 3, 0, 3};
        vecs[6] = '{5, 2, 1, 0};
        bus.transfer_data_complete_r = 0;
        bus.transfer_data_complete_w = 0;
        bus.sobel_done = 0;

        repeat (3) tick();
        chk("rst_rd_en", bus.read_enable, 0);
        chk("rst_wr_en", bus.write_enable, 0);
        chk("rst_sobel_start", bus.sobel_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_error", error, 0);
        chk("rst_col", col_idx, 0);
        chk("rst_row", row_idx, 0);
        chk("rst_single_last", single_last, 0);
        HRESETn = 1;
        tick();

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].exp_err != 0) run_err(vecs[v].len, vecs[v].wid);
            else begin
                run_frame(vecs[v].len, vecs[v].wid, 2, steps);
                chk("table_steps", steps, vecs[v].exp_steps);
            end
        end

        // start and abort together: start is dropped, sticky error survives
        img_length = 16'd6;
        img_width = 16'd4;
        start = 1;
        abort = 1;
        tick();
        start = 0;
        abort = 0;
        chk("abort_start_busy", busy, 0);
        chk("abort_keeps_error", error, 1);
        tick();
        chk("abort_start_no_read", bus.read_enable, 0);

        // abort in READ beats a simultaneous read complete
        start = 1;
        tick();
        start = 0;
        tick();
        chk("abort_read_rd_en", bus.read_enable, 1);
        abort = 1;
        bus.transfer_data_complete_r = 1;
        tick();
        abort = 0;
        bus.transfer_data_complete_r = 0;
        chk("abort_read_rd_off", bus.read_enable, 0);
        chk("abort_read_no_start", bus.sobel_start, 0);
        chk("abort_read_busy", busy, 0);
        tick();
        chk("abort_read_still_idle", bus.read_enable, 0);
        chk("abort_read_no_start2", bus.sobel_start, 0);

        // asynchronous reset while WRITE is active on the second window
        img_length = 16'd12;
        img_width = 16'd5;
        start = 1;
        tick();
        start = 0;
        tick();
        for (int s = 0; s < 2; s++) begin
            bus.transfer_data_complete_r = 1;
            tick();
            bus.transfer_data_complete_r = 0;
            bus.sobel_done = 1;
            tick();
            bus.sobel_done = 0;
            if (s == 0) begin
                bus.transfer_data_complete_w = 1;
                tick();
                bus.transfer_data_complete_w = 0;
                tick();
            end
        end
        chk("pre_reset_wr_en", bus.write_enable, 1);
        chk("pre_reset_col", col_idx, 2);
        #2;
        HRESETn = 0;
        #1;
        chk("async_rst_wr_en", bus.write_enable, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_col", col_idx, 0);
        chk("async_rst_row", row_idx, 0);
        #1;
        HRESETn = 1;
        tick();
        chk("post_reset_idle_busy", busy, 0);
        chk("post_reset_idle_rd", bus.read_enable, 0);

`ifdef SCHED_TIMEOUT_EN
        img_length = 16'd6;
        img_width = 16'd4;
        start = 1;
        tick();
        start = 0;
        tick();
        bus.transfer_data_complete_r = 1;
        tick();
        bus.transfer_data_complete_r = 0;
        chk("to_sobel_start", bus.sobel_start, 1);
        n = 0;
        while (!error && n < 100) begin
            tick();
            n++;
        end
        chk("to_sobel_cycles", n, 16);
        chk("to_busy_low", busy, 0);
        tick();
        chk("to_idle_rd", bus.read_enable, 0);
        chk("to_idle_wr", bus.write_enable, 0);
        chk("to_error_sticky", error, 1);
`endif

        for (int k = 0; k < 6; k++) begin
            int len = $urandom_range(3, 10);
            int wid = $urandom_range(3, 5);
            run_frame(len, wid, 2, steps);
            chk("rand_steps", steps, m_col.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sobel_frame_scheduler.md
Name: sobel_frame_scheduler

Overview:
Frame-level sequencer for the Sobel edge-detection datapath.
- Walks every 3x3 window position of a source image and drives ahb_master through each step: read phase (three 4-pixel row fetches), Sobel compute, write phase (two results).
- Tracks output row/column position.
- Sits between the configuration/start logic and ahb_master plus the Sobel core.

Parameters:
DIM_W, 16, width of image dimension and position counters
TIMEOUT_CYCLES, 1024, watchdog limit per wait state (used only with SCHED_TIMEOUT_EN)

Ports:
HCLK  input  1  system clock; all logic on rising edge
HRESETn  input  1  asynchronous active-low reset
start  input  1  single-cycle frame start request
abort  input  1  synchronous abort; return to IDLE
img_length  input  DIM_W  pixels per image row
img_width  input  DIM_W  number of image rows
transfer_data_complete_r  input  1  ahb_master read phase finished
transfer_data_complete_w  input  1  ahb_master write phase finished
sobel_done  input  1  Sobel core result pair valid
read_enable  output  1  to ahb_master: run read phase
write_enable  output  1  to ahb_master: run write phase
sobel_start  output  1  one-cycle pulse to Sobel core
col_idx  output  DIM_W  current output column (even, from 0)
row_idx  output  DIM_W  current output row (from 0)
single_last  output  1  current step carries only one valid result (odd output width)
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at frame completion
error  output  1  sticky until next accepted start; illegal dimensions or timeout

Behaviour:
- Reset values: all outputs 0; state IDLE.
- All outputs registered.
- Definitions: out_cols = img_length-2; out_rows = img_width-2; dimensions latched on the start-accept cycle.
- IDLE:
  - start=1 latches dimensions, clears col_idx/row_idx/error, goes to CHECK.
  - start while busy is ignored.
- CHECK (1 cycle):
  - img_length<3 or img_width<3 -> ERROR.
  - Otherwise -> READ; busy=1 from this cycle.
- READ:
  - read_enable=1 while in state.
  - On transfer_data_complete_r=1 -> SOBEL; read_enable is 0 the following cycle.
- SOBEL:
  - sobel_start=1 on the entry cycle only.
  - Wait for sobel_done=1 -> WRITE.
  - sobel_done outside SOBEL is ignored.
- WRITE:
  - write_enable=1 while in state.
  - On transfer_data_complete_w=1 -> ADVANCE.
- ADVANCE (1 cycle):
  - col_idx+2 < out_cols: col_idx += 2.
  - Else, row_idx+1 < out_rows: col_idx=0, row_idx += 1.
  - Else: DONE.
  - Next state READ unless DONE.
- single_last = (col_idx+1 == out_cols); combinationally derived from registered values, then registered.
- DONE (1 cycle): frame_done=1, busy->0, then IDLE.
- ERROR (1 cycle): error=1 (sticky), busy=0, then IDLE.
- Step latency per window: 1 cycle after read complete to sobel_start; 1 ADVANCE cycle between write complete and next read_enable.
- Abort:
  - abort=1 in any state -> IDLE next cycle; enables, busy and sobel_start cleared; error unchanged.
  - abort has priority over a simultaneous complete/done.
  - start and abort in the same cycle: abort wins; start is dropped.
- Asynchronous reset mid-frame returns everything to reset values immediately.
- Counter arithmetic is DIM_W unsigned; comparisons use DIM_W+1 bits so no wrap.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined:
  - A wait counter runs in READ, SOBEL and WRITE; it resets on every state entry.
  - Reaching TIMEOUT_CYCLES -> ERROR; enables are dropped the next cycle.
- Undefined: no counter; wait states block indefinitely.

Decomposition:
- Package sobel_sched_pkg holds:
  - state enum {IDLE, CHECK, READ, SOBEL, WRITE, ADVANCE, DONE, ERROR}
  - MIN_DIM=3 constant
  - default DIM_W
- Sub-module sobel_pos_counter:
  - col/row stepping, single_last and last-step detection.
  - Inputs: clear, advance, out_cols, out_rows.

Test Plan:
- Nominal frame: img_length=12, img_width=5; answer every phase within 3 cycles -> out_cols=10, 5 steps/row, 3 rows, 15 read/write pairs; col_idx sequence 0,2,4,6,8; frame_done pulses exactly once after the 15th write complete; busy then 0.
- Odd width: img_length=5, img_width=3 -> 2 steps at col 0 and 2; single_last=1 only on col 2; frame_done after the 2nd write.
- Illegal dimensions: img_length=2 -> error=1 two cycles after start; read_enable never asserted; a following legal start clears error.
- Abort during READ: abort while read_enable=1 and transfer_data_complete_r pulsing the same cycle -> IDLE next cycle; read_enable=0; no sobel_start.
- Async reset: HRESETn low mid-WRITE -> write_enable, busy and counters 0 immediately.
- With SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16: sobel_done never asserted -> error=1 after 16 SOBEL cycles; state returns to IDLE.
